engine_dispatcher: RTL and testbench
====================================

Name: engine_dispatcher

Overview:
- Frame-level scheduler that hands raster-order pixel coordinates to a pool of mandelbrot engines.
- Each pixel goes to whichever engine is free, chosen by round-robin, instead of stepping all engines in lockstep.
- Sits between the frame controller (start/done) and the engine array.
- Tracks which engines are busy and signals when the whole frame has been issued and drained.

Parameters:
- NUM_ENGINES, 12: number of engines served; minimum 2.
- PIXEL_DATA_WIDTH, 10: width of the x/y coordinate outputs.
- SCREEN_WIDTH, 640: pixels per line; must be <= 2^PIXEL_DATA_WIDTH.
- SCREEN_HEIGHT, 480: lines per frame; must be <= 2^PIXEL_DATA_WIDTH.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- start  in  1  begin a frame; sampled only in IDLE.
- engine_avail  in  NUM_ENGINES  per engine, level: engine and its output queue can accept a new pixel.
- engine_fin  in  NUM_ENGINES  per engine, 1-cycle pulse: engine has finished its current pixel.
- dispatch_valid  out  NUM_ENGINES  one-hot, 1-cycle pulse: the engine being loaded this cycle.
- dispatch_x  out  PIXEL_DATA_WIDTH  x coordinate, valid while any dispatch_valid bit is high.
- dispatch_y  out  PIXEL_DATA_WIDTH  y coordinate, valid while any dispatch_valid bit is high.
- busy_mask  out  NUM_ENGINES  registered per-engine busy flags.
- frame_busy  out  1  high in RUN and DRAIN.
- frame_done  out  1  1-cycle pulse when the last pixel's engine finishes.

Behaviour:
- Reset is synchronous, active-high. Any cycle with reset high, including mid-frame, forces:
  - state = IDLE; x = y = 0; busy_mask = 0;
  - dispatch_valid = 0; frame_busy = 0; frame_done = 0;
  - round-robin pointer last_grant = NUM_ENGINES-1, so engine 0 has first priority.
  - Outstanding engine_fin pulses are then ignored.
- Eligibility (combinational, from registered state): elig[i] = engine_avail[i] & ~busy_mask[i].
- Arbitration:
  - Round-robin search starting at index last_grant+1, wrapping modulo NUM_ENGINES.
  - First eligible index wins.
  - At most one grant per cycle.
- Outputs are registered. A grant decided in cycle t appears in cycle t+1:
  - dispatch_valid[g] pulses for one cycle;
  - dispatch_x/dispatch_y hold that pixel's coordinates;
  - busy_mask[g] is set at the same edge;
  - last_grant is updated to g.
- When dispatch_valid is 0, dispatch_x/dispatch_y hold their last value.
- busy_mask update per edge:
  - Set for the granted engine; cleared for each i where engine_fin[i] = 1.
  - engine_fin[i] on a non-busy engine has no effect.
  - Engine i cannot be granted in the same cycle its fin arrives, because elig uses the pre-clear mask. It becomes eligible the next cycle.
  - Fin for engine i and a grant to engine j != i in the same cycle are independent.
- States:
  - IDLE: frame_busy = 0. start = 1 -> RUN, x = y = 0. start in RUN or DRAIN is ignored.
  - RUN: frame_busy = 1. Each granted cycle advances the raster position: x+1; when x = SCREEN_WIDTH-1, x wraps to 0 and y+1.
    - If the grant is for pixel (SCREEN_WIDTH-1, SCREEN_HEIGHT-1) -> DRAIN; no further grants.
    - If no engine is eligible, the position holds and no pulse is issued; there is no timeout.
  - DRAIN: frame_busy = 1; no grants.
    - When the busy_mask after the fin updates becomes 0 -> IDLE, with frame_done pulsing in the same cycle that frame_busy falls.
- Counter widths:
  - x and y are PIXEL_DATA_WIDTH wide.
  - Comparisons are against SCREEN_WIDTH-1 and SCREEN_HEIGHT-1 truncated to PIXEL_DATA_WIDTH.
  - No wrap past the last pixel.
- Throughput: one pixel per cycle while engines are eligible. A frame issues exactly SCREEN_WIDTH*SCREEN_HEIGHT grants.
- start held high across frames: a new frame starts the cycle after frame_done (IDLE samples it).

Test Plan (use NUM_ENGINES=4, SCREEN_WIDTH=4, SCREEN_HEIGHT=2, i.e. 8 pixels):
- Basic RR: reset, engine_avail = 4'b1111, start pulse, engines never fin.
  -> Grants to engines 0,1,2,3 on 4 consecutive cycles with (x,y) = (0,0),(1,0),(2,0),(3,0).
  -> busy_mask = 4'b1111, then no grants.
- Fin recycling: continue the previous scenario and pulse engine_fin = 4'b0100.
  -> busy_mask[2] clears; the next cycle engine 2 is granted (0,1); y increments at the x wrap.
- Skip unavailable: engine_avail = 4'b1010, fin each engine 3 cycles after its grant.
  -> Grants alternate 1,3,1,3...; engines 0 and 2 are never pulsed; all 8 pixels are issued in raster order.
- Drain/done: after the 8th grant, hold fins 5 cycles, then pulse the remaining fins.
  -> No grants in DRAIN; frame_done is a single pulse the cycle busy_mask reaches 0; frame_busy falls in the same cycle; start during DRAIN is ignored.
- Simultaneous fin and grant: engine 0 fin in the same cycle engine 1 is granted.
  -> busy_mask reflects both updates.
  -> Separately, fin on engine i while it is the only avail engine: engine i is granted one cycle later, never the same cycle.
- Mid-frame reset: assert reset after 3 grants.
  -> The next cycle all outputs are 0 and state is IDLE. A new start issues (0,0) to engine 0 and a complete 8-pixel frame.

Source files
------------

// File: rtl/engine_dispatcher_if.sv
// engine_dispatcher_if: bundle between the frame controller, the engine pool
// and the dispatcher.
//   start          - begin a frame (frame controller -> dispatcher)
//   engine_avail   - per engine, level: engine can accept a pixel
//   engine_fin     - per engine, 1-cycle pulse: engine finished its pixel
//   dispatch_valid - one-hot, 1-cycle pulse: engine being loaded
//   dispatch_x/y   - coordinates of the pixel being loaded
//   busy_mask      - per-engine busy flags
//   frame_busy     - frame in progress (issuing or draining)
//   frame_done     - 1-cycle pulse when the last pixel's engine finishes
// Modport master is the dispatcher side; slave is the environment side.
interface engine_dispatcher_if #(
  parameter int NUM_ENGINES      = 12,
  parameter int PIXEL_DATA_WIDTH = 10
);
  logic                        start;
  logic [NUM_ENGINES-1:0]      engine_avail;
  logic [NUM_ENGINES-1:0]      engine_fin;
  logic [NUM_ENGINES-1:0]      dispatch_valid;
  logic [PIXEL_DATA_WIDTH-1:0] dispatch_x;
  logic [PIXEL_DATA_WIDTH-1:0] dispatch_y;
  logic [NUM_ENGINES-1:0]      busy_mask;
  logic                        frame_busy;
  logic                        frame_done;

  modport master (
    input  start, engine_avail, engine_fin,
    output dispatch_valid, dispatch_x, dispatch_y, busy_mask,
           frame_busy, frame_done
  );

  modport slave (
    output start, engine_avail, engine_fin,
    input  dispatch_valid, dispatch_x, dispatch_y, busy_mask,
           frame_busy, frame_done
  );
endinterface

// File: rtl/engine_dispatcher.sv
// engine_dispatcher: hands raster-order pixel coordinates to a pool of
// mandelbrot engines, one pixel per cycle, each to the next free engine in
// round-robin order. Tracks engine busy state and reports when a frame has
// been fully issued and drained.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high; aborts any frame in progress
//   bus   - engine_dispatcher_if.master (start, engine_avail, engine_fin in;
//           dispatch_valid, dispatch_x, dispatch_y, busy_mask, frame_busy,
//           frame_done out, all registered)
module engine_dispatcher #(
  parameter int NUM_ENGINES      = 12,
  parameter int PIXEL_DATA_WIDTH = 10,
  parameter int SCREEN_WIDTH     = 640,
  parameter int SCREEN_HEIGHT    = 480
) (
  input  logic                clk,
  input  logic                reset,
  engine_dispatcher_if.master bus
);
  localparam int IW = $clog2(NUM_ENGINES);
  localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST = PIXEL_DATA_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] Y_LAST = PIXEL_DATA_WIDTH'(SCREEN_HEIGHT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ENGINES - 1);
  localparam logic [IW:0]   N_EXT    = (IW+1)'(NUM_ENGINES);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                      state;
  logic [PIXEL_DATA_WIDTH-1:0] x;
  logic [PIXEL_DATA_WIDTH-1:0] y;
  logic [IW-1:0]               last_grant;

  logic [NUM_ENGINES-1:0] elig;
  logic [NUM_ENGINES-1:0] grant_vec;
  logic [NUM_ENGINES-1:0] busy_next;
  logic [IW-1:0]          grant_idx;
  logic                   grant_found;
  logic                   grant_ok;
  logic [IW:0]            cand;

  // Round-robin pick: scan last_grant+1 .. last_grant+NUM_ENGINES modulo
  // NUM_ENGINES. Eligibility uses the registered busy mask, so an engine
  // whose fin arrives this cycle is only eligible from the next cycle on.
  always_comb begin
    elig        = bus.engine_avail & ~bus.busy_mask;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_ENGINES; k++) begin
      cand = {1'b0, last_grant} + (IW+1)'(k);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!grant_found && elig[cand[IW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IW-1:0];
      end
    end
    grant_ok  = (state == RUN) && grant_found;
    grant_vec = '0;
    if (grant_ok) grant_vec[grant_idx] = 1'b1;
    // A granted engine is never busy beforehand, so clearing fins first and
    // then setting the grant cannot lose either update.
    busy_next = (bus.busy_mask & ~bus.engine_fin) | grant_vec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      x                  <= '0;
      y                  <= '0;
      last_grant         <= LAST_IDX;
      bus.busy_mask      <= '0;
      bus.dispatch_valid <= '0;
      bus.dispatch_x     <= '0;
      bus.dispatch_y     <= '0;
      bus.frame_busy     <= 1'b0;
      bus.frame_done     <= 1'b0;
    end else begin
      bus.dispatch_valid <= '0;
      bus.frame_done     <= 1'b0;
      bus.busy_mask      <= busy_next;
      case (state)
        IDLE: begin
          bus.frame_busy <= 1'b0;
          if (bus.start) begin
            state          <= RUN;
            x              <= '0;
            y              <= '0;
            bus.frame_busy <= 1'b1;
          end
        end
        RUN: begin
          if (grant_ok) begin
            bus.dispatch_valid <= grant_vec;
            bus.dispatch_x     <= x;
            bus.dispatch_y     <= y;
            last_grant         <= grant_idx;
            if (x == X_LAST) begin
              x <= '0;
              // Last pixel of the frame: stop issuing, keep the position.
              if (y == Y_LAST) begin
                x     <= x;
                state <= DRAIN;
              end else begin
                y <= y + 1'b1;
              end
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (busy_next == '0) begin
            state          <= IDLE;
            bus.frame_busy <= 1'b0;
            bus.frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_engine_dispatcher.sv
// tb_engine_dispatcher: directed and randomized checks of engine_dispatcher
// against a pixel-index / busy-set reference model (4 engines, 4x2 frame).
module tb_engine_dispatcher;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int PW = 10;

  logic clk;
  logic reset;

  engine_dispatcher_if #(.NUM_ENGINES(N), .PIXEL_DATA_WIDTH(PW)) bus ();

  engine_dispatcher #(
    .NUM_ENGINES(N), .PIXEL_DATA_WIDTH(PW),
    .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: phase 0 idle, 1 issuing, 2 draining.
  int             m_phase = 0;
  int             m_pix   = 0;
  int             m_last  = N - 1;
  logic [N-1:0]   m_busy  = '0;
  logic [N-1:0]   m_dv    = '0;
  logic [PW-1:0]  m_x     = '0;
  logic [PW-1:0]  m_y     = '0;
  logic           m_fb    = 1'b0;
  logic           m_fd    = 1'b0;

  // Engine behaviour and grant log.
  bit  auto_fin   = 0;
  bit  fin_rand   = 0;
  bit  rand_avail = 0;
  int  cnt [N];
  int  log_g[$];
  int  log_x[$];
  int  log_y[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // What the next clock edge must produce, from the inputs now applied.
  task automatic model_edge();
    logic [N-1:0] nb;
    int g;
    if (reset) begin
      m_phase = 0; m_pix = 0; m_last = N - 1; m_busy = '0;
      m_dv = '0; m_x = '0; m_y = '0; m_fb = 1'b0; m_fd = 1'b0;
    end else begin
      m_dv = '0;
      m_fd = 1'b0;
      g = -1;
      if (m_phase == 1) begin
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (m_last + k) % N;
          if (g < 0 && bus.engine_avail[idx] && !m_busy[idx]) g = idx;
        end
      end
      nb = m_busy & ~bus.engine_fin;
      if (g >= 0) nb[g] = 1'b1;
      case (m_phase)
        0: if (bus.start) begin m_phase = 1; m_pix = 0; m_fb = 1'b1; end
        1: if (g >= 0) begin
             m_dv[g] = 1'b1;
             m_x = PW'(m_pix % W);
             m_y = PW'(m_pix / W);
             m_last = g;
             if (m_pix == W*H - 1) m_phase = 2;
             else m_pix++;
           end
        default: if (nb == '0) begin m_phase = 0; m_fb = 1'b0; m_fd = 1'b1; end
      endcase
      m_busy = nb;
    end
  endtask

  task automatic cycle();
    logic [N-1:0] fin_next;
    model_edge();
    @(posedge clk);
    #1;
    check("dispatch_valid", 32'(bus.dispatch_valid), 32'(m_dv));
    check("dispatch_x",     32'(bus.dispatch_x),     32'(m_x));
    check("dispatch_y",     32'(bus.dispatch_y),     32'(m_y));
    check("busy_mask",      32'(bus.busy_mask),      32'(m_busy));
    check("frame_busy",     32'(bus.frame_busy),     32'(m_fb));
    check("frame_done",     32'(bus.frame_done),     32'(m_fd));
    for (int i = 0; i < N; i++) begin
      if (bus.dispatch_valid[i] === 1'b1) begin
        log_g.push_back(i);
        log_x.push_back(int'(bus.dispatch_x));
        log_y.push_back(int'(bus.dispatch_y));
      end
    end
    if (auto_fin) begin
      fin_next = '0;
      for (int i = 0; i < N; i++) begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) fin_next[i] = 1'b1;
        end
        if (bus.dispatch_valid[i] === 1'b1)
          cnt[i] = fin_rand ? int'($urandom_range(1, 4)) : 3;
      end
      bus.engine_fin = fin_next;
    end
    if (rand_avail) bus.engine_avail = N'($urandom);
  endtask

  task automatic clear_log();
    log_g.delete(); log_x.delete(); log_y.delete();
  endtask

  task automatic clear_cnt();
    for (int i = 0; i < N; i++) cnt[i] = 0;
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    bit seen;
    seen = 0;
    for (int c = 0; c < max_cyc && !seen; c++) begin
      cycle();
      if (bus.frame_done === 1'b1) seen = 1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  // Whole frame issued exactly once, in raster order.
  task automatic check_raster(input string tag);
    check({tag, "_count"}, 32'(log_g.size()), 32'(W*H));
    for (int k = 0; k < log_g.size() && k < W*H; k++) begin
      check({tag, "_x"}, 32'(log_x[k]), 32'(k % W));
      check({tag, "_y"}, 32'(log_y[k]), 32'(k / W));
    end
  endtask

  initial begin
    clear_cnt();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.engine_avail = '0;
    bus.engine_fin = '0;
    cycle();
    cycle();
    check("reset_dv",   32'(bus.dispatch_valid), 32'd0);
    check("reset_busy", 32'(bus.busy_mask),      32'd0);
    check("reset_fb",   32'(bus.frame_busy),     32'd0);

    // Basic round-robin, engines never finish.
    reset = 1'b0;
    bus.engine_avail = 4'b1111;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    check("run_fb", 32'(bus.frame_busy), 32'd1);
    clear_log();
    repeat (6) cycle();
    check("rr_count", 32'(log_g.size()), 32'd4);
    for (int k = 0; k < log_g.size() && k < 4; k++) begin
      check("rr_eng", 32'(log_g[k]), 32'(k));
      check("rr_x",   32'(log_x[k]), 32'(k));
      check("rr_y",   32'(log_y[k]), 32'd0);
    end
    check("rr_busy", 32'(bus.busy_mask), 32'hF);

    // Fin recycling: engine 2 frees, then takes pixel (0,1).
    bus.engine_fin = 4'b0100;
    cycle();
    bus.engine_fin = '0;
    check("fin_clear", 32'(bus.busy_mask), 32'b1011);
    check("fin_nogrant", 32'(bus.dispatch_valid), 32'd0);
    cycle();
    check("recycle_dv", 32'(bus.dispatch_valid), 32'b0100);
    check("recycle_x",  32'(bus.dispatch_x), 32'd0);
    check("recycle_y",  32'(bus.dispatch_y), 32'd1);

    // Release everything and let the frame complete.
    bus.engine_fin = 4'b1111;
    cycle();
    bus.engine_fin = '0;
    clear_cnt();
    auto_fin = 1;
    wait_done(60, "frame1_done");
    cycle();

    // Skip unavailable engines 0 and 2.
    bus.engine_avail = 4'b1010;
    clear_log();
    clear_cnt();
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    for (int c = 0; c < 100 && log_g.size() < W*H; c++) cycle();
    auto_fin = 0;
    bus.engine_fin = '0;
    clear_cnt();
    check_raster("skip");
    for (int k = 0; k < log_g.size(); k++) begin
      check("skip_odd", 32'(log_g[k] == 1 || log_g[k] == 3), 32'd1);
      if (k > 0) check("skip_alt", 32'(log_g[k] != log_g[k-1]), 32'd1);
    end

    // Drain: fins held, start ignored, then all fins at once.
    bus.start = 1'b1;
    repeat (5) begin
      cycle();
      check("drain_nogrant", 32'(bus.dispatch_valid), 32'd0);
      check("drain_fb",      32'(bus.frame_busy),     32'd1);
      check("drain_nodone",  32'(bus.frame_done),     32'd0);
    end
    bus.start = 1'b0;
    bus.engine_fin = 4'b1111;
    cycle();
    bus.engine_fin = '0;
    check("done_pulse", 32'(bus.frame_done), 32'd1);
    check("done_fb",    32'(bus.frame_busy), 32'd0);
    check("done_busy",  32'(bus.busy_mask),  32'd0);
    cycle();
    check("done_single", 32'(bus.frame_done), 32'd0);
    check("idle_fb",     32'(bus.frame_busy), 32'd0);

    // Simultaneous fin and grant.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    bus.engine_avail = 4'b0011;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    cycle();
    check("sim_g0", 32'(bus.dispatch_valid), 32'b0001);
    bus.engine_fin = 4'b0001;
    cycle();
    bus.engine_fin = '0;
    check("sim_g1",   32'(bus.dispatch_valid), 32'b0010);
    check("sim_busy", 32'(bus.busy_mask),      32'b0010);
    bus.engine_avail = 4'b0001;
    cycle();
    check("only_g0", 32'(bus.dispatch_valid), 32'b0001);
    bus.engine_fin = 4'b0001;
    cycle();
    bus.engine_fin = '0;
    check("only_nosame", 32'(bus.dispatch_valid), 32'd0);
    check("only_busy",   32'(bus.busy_mask),      32'b0010);
    cycle();
    check("only_next", 32'(bus.dispatch_valid), 32'b0001);

    // Mid-frame reset after three grants.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    bus.engine_avail = 4'b1111;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    clear_log();
    repeat (3) cycle();
    check("mid_grants", 32'(log_g.size()), 32'd3);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("mid_dv",   32'(bus.dispatch_valid), 32'd0);
    check("mid_x",    32'(bus.dispatch_x),     32'd0);
    check("mid_y",    32'(bus.dispatch_y),     32'd0);
    check("mid_busy", 32'(bus.busy_mask),      32'd0);
    check("mid_fb",   32'(bus.frame_busy),     32'd0);
    check("mid_fd",   32'(bus.frame_done),     32'd0);
    clear_log();
    clear_cnt();
    auto_fin = 1;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    wait_done(100, "mid_frame_done");
    if (log_g.size() > 0) check("mid_first_eng", 32'(log_g[0]), 32'd0);
    check_raster("mid");

    // Random availability and fin delays, start held across two frames.
    fin_rand = 1;
    rand_avail = 1;
    clear_log();
    bus.start = 1'b1;
    wait_done(400, "rand1_done");
    check_raster("rand1");
    clear_log();
    wait_done(400, "rand2_done");
    bus.start = 1'b0;
    check_raster("rand2");
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
